// File: rtl/dds_pkg.sv
// Shared DDS stream definitions: sample packing defaults, beat vector type,
// tone-meter state encoding and the crossing-count width helper.
package dds_pkg;

    localparam int DDS_SAMPLE_WIDTH     = 18;
    localparam int DDS_PARALLEL_SAMPLES = 4;

    // One beat of PARALLEL_SAMPLES signed samples, lane 0 (oldest) in the LSBs.
    typedef logic [DDS_PARALLEL_SAMPLES*DDS_SAMPLE_WIDTH-1:0] sample_beat_t;

    typedef enum logic {
        METER_IDLE,
        METER_COUNT
    } meter_state_t;

    function automatic int count_bits(input int gate_bits, input int parallel_samples);
        return gate_bits + $clog2(parallel_samples + 1);
    endfunction

endpackage

// File: rtl/zero_cross_detect.sv
// Hysteretic rising-zero-crossing detector over one beat of parallel samples;
// the armed flag carries from the newest lane of one beat to the oldest of the next.
module zero_cross_detect #(
    parameter int SAMPLE_WIDTH     = 18,
    parameter int PARALLEL_SAMPLES = 4,
    parameter int HYST             = 64,
    localparam int CROSS_BITS      = $clog2(PARALLEL_SAMPLES + 1)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      beat_valid,
    input  logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0]  beat_data,
    output logic [CROSS_BITS-1:0]                     crossings
);

    localparam logic signed [SAMPLE_WIDTH-1:0] POS_TH = SAMPLE_WIDTH'(HYST);
    localparam logic signed [SAMPLE_WIDTH-1:0] NEG_TH = -POS_TH;

    logic armed;
    logic armed_next;

    // NOTE: blocking assignments here model the lane-to-lane chain; each lane sees
    // the armed value left by the previous lane in the same beat.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        armed_next = armed;
        crossings  = '0;
        for (int i = 0; i < PARALLEL_SAMPLES; i++) begin
            if ($signed(beat_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]) < NEG_TH) begin
                armed_next = 1'b1;
            end else if (armed_next &&
                         $signed(beat_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]) >= POS_TH) begin
                crossings  = crossings + CROSS_BITS'(1);
                armed_next = 1'b0;
            end
        end
    end

    // The detector tracks every valid beat, counting or not, so arming survives gate changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (beat_valid) begin
            armed <= armed_next;
        end
    end

endmodule

// File: rtl/tone_freq_meter.sv
// Counts rising zero crossings of a parallel sample stream over a programmable
// gate of valid beats and reports one {overrun, count} result per window.
module tone_freq_meter
    import dds_pkg::*;
#(
    parameter int SAMPLE_WIDTH     = DDS_SAMPLE_WIDTH,
    parameter int PARALLEL_SAMPLES = DDS_PARALLEL_SAMPLES,
    parameter int GATE_BITS        = 16,
    parameter int HYST             = 64,
    localparam int COUNT_BITS      = count_bits(GATE_BITS, PARALLEL_SAMPLES),
    localparam int CROSS_BITS      = $clog2(PARALLEL_SAMPLES + 1)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0]  samples_in_data,
    input  logic                                      samples_in_valid,
    output logic                                      samples_in_ready,
    input  logic [GATE_BITS-1:0]                      gate_len_in_data,
    input  logic                                      gate_len_in_valid,
    output logic                                      gate_len_in_ready,
    output logic [COUNT_BITS:0]                       freq_out_data,
    output logic                                      freq_out_valid,
    input  logic                                      freq_out_ready
);

    meter_state_t            state;
    logic [GATE_BITS-1:0]    gate_len;
    logic [GATE_BITS-1:0]    beat_cnt;
    logic [CROSS_BITS-1:0]   cross_now;
    logic [CROSS_BITS-1:0]   cross_q;
    logic                    cross_valid_q;
    logic                    close_q;
    logic [COUNT_BITS-1:0]   acc;
    logic                    counting_beat;
    logic                    closing_beat;

    assign samples_in_ready  = 1'b1;
    assign gate_len_in_ready = 1'b1;

    assign counting_beat = (state == METER_COUNT) && samples_in_valid;
    assign closing_beat  = counting_beat && (beat_cnt == gate_len - GATE_BITS'(1));

    zero_cross_detect #(
        .SAMPLE_WIDTH     (SAMPLE_WIDTH),
        .PARALLEL_SAMPLES (PARALLEL_SAMPLES),
        .HYST             (HYST)
    ) u_detect (
        .clk        (clk),
        .reset      (reset),
        .beat_valid (samples_in_valid),
        .beat_data  (samples_in_data),
        .crossings  (cross_now)
    );

    // Stage 1: gate FSM and beat counter; registers this beat's crossing count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= METER_IDLE;
            gate_len      <= '0;
            beat_cnt      <= '0;
            cross_q       <= '0;
            cross_valid_q <= 1'b0;
            close_q       <= 1'b0;
        end else begin
            cross_q <= cross_now;
            if (gate_len_in_valid) begin
                gate_len      <= gate_len_in_data;
                beat_cnt      <= '0;
                state         <= (gate_len_in_data != '0) ? METER_COUNT : METER_IDLE;
                cross_valid_q <= 1'b0;
                close_q       <= 1'b0;
            end else begin
                cross_valid_q <= counting_beat;
                close_q       <= closing_beat;
                if (counting_beat) begin
                    beat_cnt <= closing_beat ? '0 : beat_cnt + GATE_BITS'(1);
                end
            end
        end
    end

    // Stage 2: accumulate, close the window and hold the result until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc            <= '0;
            freq_out_valid <= 1'b0;
            freq_out_data  <= '0;
        end else begin
            if (close_q) begin
                freq_out_data  <= {freq_out_valid && !freq_out_ready,
                                   acc + COUNT_BITS'(cross_q)};
                freq_out_valid <= 1'b1;
            end else if (freq_out_valid && freq_out_ready) begin
                freq_out_valid <= 1'b0;
            end

            if (gate_len_in_valid || close_q) begin
                acc <= '0;
            end else if (cross_valid_q) begin
                acc <= acc + COUNT_BITS'(cross_q);
            end
        end
    end

endmodule

// File: tb/tb_tone_freq_meter.sv
// Directed scenarios with randomized samples/valids, checked cycle by cycle
// against a beat-level arithmetic model of the tone meter.
module tb_tone_freq_meter;
    import dds_pkg::*;

    localparam int SW   = 18;
    localparam int P    = 4;
    localparam int GB   = 16;
    localparam int HYST = 64;
    localparam int CB   = count_bits(GB, P);

    logic              clk = 1'b0;
    logic              reset;
    sample_beat_t      samples_in_data;
    logic              samples_in_valid;
    logic              samples_in_ready;
    logic [GB-1:0]     gate_len_in_data;
    logic              gate_len_in_valid;
    logic              gate_len_in_ready;
    logic [CB:0]       freq_out_data;
    logic              freq_out_valid;
    logic              freq_out_ready;

    tone_freq_meter #(
        .SAMPLE_WIDTH     (SW),
        .PARALLEL_SAMPLES (P),
        .GATE_BITS        (GB),
        .HYST             (HYST)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .samples_in_data   (samples_in_data),
        .samples_in_valid  (samples_in_valid),
        .samples_in_ready  (samples_in_ready),
        .gate_len_in_data  (gate_len_in_data),
        .gate_len_in_valid (gate_len_in_valid),
        .gate_len_in_ready (gate_len_in_ready),
        .freq_out_data     (freq_out_data),
        .freq_out_valid    (freq_out_valid),
        .freq_out_ready    (freq_out_ready)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: whole-window arithmetic, result shows up one edge after the closing beat.
    bit          m_armed;
    int          m_gate;
    int          m_beats;
    int          m_acc;
    bit          m_pend;
    int          m_pend_val;
    bit          m_valid;
    logic [CB:0] m_data;

    int          tone_tab[64];
    int          tone_idx = 0;
    int          cyc = 0;
    int          res_cyc[$];
    logic [CB:0] res_data[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_gate = 0; m_beats = 0; m_acc = 0;
        m_pend = 0; m_pend_val = 0; m_valid = 0; m_data = '0;
    endtask

    function automatic int lane(input sample_beat_t b, input int i);
        logic signed [SW-1:0] s;
        s = b[i*SW +: SW];
        return int'(s);
    endfunction

    task automatic tone_beat(output sample_beat_t b);
        b = '0;
        for (int i = 0; i < P; i++) begin
            b[i*SW +: SW] = SW'(tone_tab[tone_idx]);
            tone_idx = (tone_idx + 1) % 64;
        end
    endtask

    task automatic noise_beat(output sample_beat_t b);
        b = '0;
        for (int i = 0; i < P; i++) begin
            b[i*SW +: SW] = SW'(int'($urandom_range(120, 0)) - 60);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input bit sv, input sample_beat_t sd, input bit gv,
                        input int gd, input bit rdy);
        int  c;
        bit  fresh;
        samples_in_valid  = sv;
        samples_in_data   = sd;
        gate_len_in_valid = gv;
        gate_len_in_data  = GB'(gd);
        freq_out_ready    = rdy;

        fresh = 0;
        if (m_pend) begin
            m_data  = {m_valid && !rdy, CB'(m_pend_val)};
            m_valid = 1;
            fresh   = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_pend = 0;

        c = 0;
        if (sv) begin
            for (int i = 0; i < P; i++) begin
                if (lane(sd, i) < -HYST) m_armed = 1;
                else if (m_armed && lane(sd, i) >= HYST) begin
                    c++;
                    m_armed = 0;
                end
            end
        end
        if (gv) begin
            m_gate = gd; m_beats = 0; m_acc = 0;
        end else if (sv && m_gate != 0) begin
            m_acc += c;
            m_beats++;
            if (m_beats == m_gate) begin
                m_pend = 1; m_pend_val = m_acc; m_acc = 0; m_beats = 0;
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (fresh) begin
            res_cyc.push_back(cyc);
            res_data.push_back(m_data);
        end
        check("valid", {63'd0, freq_out_valid}, {63'd0, m_valid});
        check("data", 64'(freq_out_data), 64'(m_data));
    endtask

    task automatic run(input int n, input bit tone, input int vpct, input bit rdy);
        for (int k = 0; k < n; k++) begin
            sample_beat_t b;
            bit           sv;
            sv = ($urandom_range(99, 0) < vpct);
            b  = '0;
            if (sv) begin
                if (tone) tone_beat(b);
                else      noise_beat(b);
            end
            step(sv, b, 0, 0, rdy);
        end
    endtask

    task automatic write_gate(input int len, input bit tone);
        sample_beat_t b;
        if (tone) tone_beat(b);
        else      noise_beat(b);
        step(1, b, 1, len, 1);
        res_cyc.delete();
        res_data.delete();
    endtask

    initial begin
        int g0;
        for (int n = 0; n < 64; n++) begin
            tone_tab[n] = $rtoi(100000.0 * $cos(2.0 * 3.14159265358979 * n / 64.0));
        end

        reset             = 1'b1;
        samples_in_valid  = 1'b0;
        samples_in_data   = '0;
        gate_len_in_valid = 1'b0;
        gate_len_in_data  = '0;
        freq_out_ready    = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_valid", {63'd0, freq_out_valid}, 64'd0);
        check("reset_data", 64'(freq_out_data), 64'd0);
        check("ready_tied", {62'd0, samples_in_ready, gate_len_in_ready}, 64'd3);
        reset = 1'b0;

        // 1: continuous tone, 64-sample period, gate 1024 beats
        write_gate(1024, 1);
        run(2060, 1, 100, 1);
        check("t1_nres", 64'(res_data.size()), 64'd2);
        if (res_data.size() == 2) begin
            check("t1_first_range",
                  {63'd0, (res_data[0][CB-1:0] >= 63 && res_data[0][CB-1:0] <= 65)}, 64'd1);
            check("t1_second", 64'(res_data[1]), 64'd64);
        end

        // 2: same tone, 50% valid beats; results spaced about 2048 cycles
        write_gate(1024, 1);
        g0 = cyc;
        run(4400, 1, 50, 1);
        check("t2_nres_ge2", {63'd0, res_data.size() >= 2}, 64'd1);
        if (res_data.size() >= 2) begin
            check("t2_count0", 64'(res_data[0]), 64'd64);
            check("t2_count1", 64'(res_data[1]), 64'd64);
            check("t2_spacing", {63'd0, (res_cyc[0] - g0 > 1850) && (res_cyc[0] - g0 < 2250) &&
                                 (res_cyc[1] - res_cyc[0] > 1800) && (res_cyc[1] - res_cyc[0] < 2300)},
                  64'd1);
        end

        // 3: noise inside the hysteresis band never counts
        write_gate(256, 0);
        run(600, 0, 100, 1);
        check("t3_nres", 64'(res_data.size()), 64'd2);
        foreach (res_data[i]) check("t3_zero", 64'(res_data[i]), 64'd0);

        // 4: results not taken for three windows -> overrun; then accepted
        write_gate(1024, 1);
        run(3 * 1024 + 20, 1, 100, 0);
        check("t4_nres", 64'(res_data.size()), 64'd3);
        check("t4_held_valid", {63'd0, freq_out_valid}, 64'd1);
        check("t4_held_data", 64'(freq_out_data), 64'((1 << CB) | 64));
        run(5, 1, 100, 1);
        check("t4_accepted", {63'd0, freq_out_valid}, 64'd0);
        res_data.delete();
        run(1100, 1, 100, 1);
        check("t4_next_nres", 64'(res_data.size()), 64'd1);
        if (res_data.size() == 1) check("t4_next_clean", 64'(res_data[0]), 64'd64);

        // 5: abort window with a rewrite, then gate 0 -> idle; then gate 1
        write_gate(1024, 1);
        run(300, 1, 100, 1);
        write_gate(100, 1);
        run(50, 1, 100, 1);
        write_gate(0, 1);
        run(300, 1, 100, 1);
        check("t5_idle_nres", 64'(res_data.size()), 64'd0);
        write_gate(1, 1);
        run(20, 1, 100, 1);
        check("t5_gate1_nres", 64'(res_data.size()), 64'd19);
        foreach (res_data[i]) check("t5_gate1_range", {63'd0, res_data[i] <= 4}, 64'd1);

        // 6: asynchronous reset while a result is held
        write_gate(1, 1);
        run(5, 1, 100, 0);
        check("t6_pre_valid", {63'd0, freq_out_valid}, 64'd1);
        #2 reset = 1'b1;
        #1 check("t6_async_drop", {63'd0, freq_out_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        res_data.delete();
        run(60, 1, 100, 1);
        check("t6_no_output", 64'(res_data.size()), 64'd0);
        write_gate(16, 1);
        run(40, 1, 100, 1);
        check("t6_resume_nres", 64'(res_data.size()), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
